// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction-fetch front end feeding the decode stage. It keeps a single
// request outstanding to instruction memory (req/ack) and buffers returned
// words, together with their PCs, in a small FIFO. Decode drains the FIFO
// through a valid/ready handshake. A redirect from execute flushes the FIFO,
// restarts fetch at the new PC and discards any response still in flight.
//
// Parameters
//   DEPTH          FIFO entries (power of two, >= 2)
//   RESET_PC       first fetch address after reset
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   redirect_i     flush queue and restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch address (word aligned)
//   imem_req_o     request valid, held with imem_addr_o stable until ack
//   imem_addr_o    request address
//   imem_ack_i     response valid (only meaningful while imem_req_o=1)
//   imem_rdata_i   instruction word returned with imem_ack_i
//   dec_valid_o    head entry is valid
//   dec_instr_o    head instruction (zero when the queue is empty)
//   dec_pc_o       head instruction address (zero when the queue is empty)
//   dec_ready_i    decode consumes the head entry this cycle
//   count_o        current queue occupancy
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_rdata_i,
  output logic                   dec_valid_o,
  output logic [31:0]            dec_instr_o,
  output logic [31:0]            dec_pc_o,
  input  logic                   dec_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];
  logic             push, pop, room;

  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr_o = req_pc_q;
  assign dec_valid_o = (count_q != '0);
  assign count_o     = count_q;

  // The storage array has no reset, so the head is gated to keep the
  // decode-facing outputs at zero whenever nothing valid is queued.
  assign dec_instr_o = dec_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign dec_pc_o    = dec_valid_o ? pc_mem_q[rd_ptr_q]    : 32'h0;

  // A redirect kills both the consume and the fill of the current cycle.
  assign pop        = dec_valid_o & dec_ready_i & ~redirect_i;
  assign push       = (state_q == ST_REQ) & imem_ack_i & ~redirect_i;
  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  // A new request is only launched when its word is guaranteed a slot,
  // which is what keeps a push from ever landing on a full queue.
  assign room = (count_next < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          state_d  = ST_REQ;
          req_pc_d = redirect_pc_i;
        end else if (room) begin
          state_d  = ST_REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (imem_ack_i && !redirect_i) begin
          fetch_pc_d = req_pc_q + 32'd4;
          if (room) begin
            req_pc_d = req_pc_q + 32'd4;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (imem_ack_i && redirect_i) begin
          // Response arrived with the redirect: drop it, start the new stream.
          req_pc_d = redirect_pc_i;
        end else if (redirect_i) begin
          // The old request must still complete; remember where to go next.
          state_d    = ST_DRAIN;
          fetch_pc_d = redirect_pc_i;
        end
      end
      ST_DRAIN: begin
        if (imem_ack_i && redirect_i) begin
          // The freshest redirect wins even when it lands on the ack cycle.
          state_d    = ST_REQ;
          req_pc_d   = redirect_pc_i;
          fetch_pc_d = redirect_pc_i;
        end else if (imem_ack_i) begin
          state_d  = ST_REQ;
          req_pc_d = fetch_pc_q;
        end else if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      req_pc_q   <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// The driver acts as instruction memory (configurable latency, data derived
// from the address) and as the execute/decode neighbours. Whenever fetch is
// (re)started the driver loads the expected instruction stream into a
// scoreboard queue: consecutive words from the restart PC. A separate monitor
// pops that queue each time decode consumes a word and compares PC and data.
// Directed sequences cover the reset, stall, drain and redirect scenarios.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } expT;

  logic                   clk = 1'b0;
  logic                   rstN;
  logic                   redirect;
  logic [31:0]            redirectPc;
  logic                   imemReq;
  logic [31:0]            imemAddr;
  logic                   imemAck;
  logic [31:0]            imemRdata;
  logic                   decValid;
  logic [31:0]            decInstr;
  logic [31:0]            decPc;
  logic                   decReady;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int ackCount = 0;
  int memWait = 0;
  int memLatency = 0;
  int latMin = 0;
  int latMax = 0;
  logic lastAck = 1'b0;
  logic lastRedir = 1'b0;
  logic [31:0] genPc = 32'h0;
  expT expectQ[$];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .redirect_i   (redirect),
    .redirect_pc_i(redirectPc),
    .imem_req_o   (imemReq),
    .imem_addr_o  (imemAddr),
    .imem_ack_i   (imemAck),
    .imem_rdata_i (imemRdata),
    .dec_valid_o  (decValid),
    .dec_instr_o  (decInstr),
    .dec_pc_o     (decPc),
    .dec_ready_i  (decReady),
    .count_o      (count)
  );

  // Memory contents: a scrambled function of the address.
  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic topUp();
    while (expectQ.size() < 64) begin
      expectQ.push_back('{pc: genPc, instr: instrFor(genPc)});
      genPc = genPc + 32'd4;
    end
  endtask

  task automatic restartStream(input logic [31:0] pc);
    expectQ.delete();
    genPc = pc;
    topUp();
  endtask

  // One cycle of stimulus at the falling edge: memory response first, then
  // the execute redirect and the decode stall.
  task automatic applyStimulus(input logic redir, input logic [31:0] redirPc,
                               input logic ready, input logic redirOnAck);
    logic ack;
    @(negedge clk);
    ack = 1'b0;
    if (rstN && imemReq) begin
      if (memWait >= memLatency) begin
        ack = 1'b1;
        memWait = 0;
        memLatency = int'($urandom_range(latMax, latMin));
        ackCount++;
      end else begin
        memWait++;
      end
    end else begin
      memWait = 0;
    end
    imemAck = ack;
    imemRdata = ack ? instrFor(imemAddr) : $urandom();
    lastAck = ack;
    lastRedir = redirOnAck ? (redir && ack) : redir;
    redirect = lastRedir;
    redirectPc = redirPc;
    decReady = ready;
    if (lastRedir) restartStream(redirPc);
    topUp();
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic resetDut(input int lat, input logic ready);
    #1;
    rstN = 1'b0;
    restartStream(RESET_PC);
    latMin = lat;
    latMax = lat;
    memLatency = lat;
    repeat (2) applyStimulus(1'b0, 32'h0, ready, 1'b0);
    rstN = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " imem_req"}, 32'(imemReq), 32'h0);
    checkOutput({tag, " imem_addr"}, imemAddr, RESET_PC);
    checkOutput({tag, " dec_valid"}, 32'(decValid), 32'h0);
    checkOutput({tag, " dec_instr"}, decInstr, 32'h0);
    checkOutput({tag, " dec_pc"}, decPc, 32'h0);
    checkOutput({tag, " count"}, 32'(count), 32'h0);
  endtask

  // Monitor: protocol invariants plus in-order scoreboard of consumed words.
  initial begin : monitor
    logic prevRedir;
    logic prevWait;
    logic [31:0] prevAddr;
    expT e;
    prevRedir = 1'b0;
    prevWait = 1'b0;
    prevAddr = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstN) begin
        prevRedir = 1'b0;
        prevWait = 1'b0;
      end else begin
        checkOutput("valid vs count", 32'(decValid), 32'(count != 0));
        checkOutput("count bound", 32'(count <= DEPTH), 32'h1);
        if (prevRedir) checkOutput("valid after redirect", 32'(decValid), 32'h0);
        if (prevWait) begin
          checkOutput("addr stable", imemAddr, prevAddr);
          checkOutput("req held", 32'(imemReq), 32'h1);
        end
        if (decValid && decReady && !redirect) begin
          if (expectQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard empty: got pc %h expected none", decPc);
          end else begin
            e = expectQ.pop_front();
            checkOutput("dec_pc", decPc, e.pc);
            checkOutput("dec_instr", decInstr, e.instr);
            pops++;
          end
        end
        prevRedir = redirect;
        prevWait = imemReq && !imemAck;
        prevAddr = imemAddr;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    int startAcks;
    int startPops;
    int tries;
    logic [31:0] rp;
    logic rr;

    rstN = 1'b0;
    redirect = 1'b0;
    redirectPc = 32'h0;
    imemAck = 1'b0;
    imemRdata = 32'h0;
    decReady = 1'b1;
    restartStream(RESET_PC);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkResetValues("reset");

    // Zero-wait memory, decode always ready: one word per cycle.
    $display("[TB] zero-wait streaming");
    resetDut(0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("zw imem_req", 32'(imemReq), 32'h1);
      checkOutput("zw imem_addr", imemAddr, 32'(4 * (k - 1)));
      if (k >= 2) checkOutput("zw dec_pc", decPc, 32'(4 * (k - 2)));
    end

    // Decode stalled: queue fills to DEPTH and fetch stops.
    $display("[TB] stall until full");
    resetDut(0, 1'b0);
    startAcks = ackCount;
    repeat (9) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall pushes", 32'(ackCount - startAcks), 32'd4);
    checkOutput("stall count", 32'(count), 32'd4);
    checkOutput("stall imem_req", 32'(imemReq), 32'h0);
    checkOutput("stall head pc", decPc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("unstall imem_req", 32'(imemReq), 32'h1);
    checkOutput("unstall imem_addr", imemAddr, 32'h10);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Redirect while a slow request is pending: drain, then restart.
    $display("[TB] redirect during pending request");
    resetDut(3, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
    checkOutput("pend imem_addr", imemAddr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("drain hold addr", imemAddr, 32'h0);
      checkOutput("drain hold req", 32'(imemReq), 32'h1);
    end
    checkOutput("drain ack seen", 32'(lastAck), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post-drain addr", imemAddr, 32'h100);
    checkOutput("post-drain count", 32'(count), 32'h0);
    tries = 0;
    while (!decValid && tries < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tries++;
    end
    checkOutput("first pc after drain", decPc, 32'h100);
    checkOutput("first instr after drain", decInstr, instrFor(32'h100));
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Redirect on the same cycle as the memory ack.
    $display("[TB] redirect coincident with ack");
    resetDut(1, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tries = 0;
    do begin
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
      tries++;
    end while (!lastRedir && tries < 10);
    checkOutput("redirect on ack", 32'(lastRedir), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("ack-redirect addr", imemAddr, 32'h200);
    checkOutput("ack-redirect req", 32'(imemReq), 32'h1);
    checkOutput("ack-redirect count", 32'(count), 32'h0);
    checkOutput("ack-redirect valid", 32'(decValid), 32'h0);
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Two redirects while draining: the later one is where fetch resumes.
    $display("[TB] double redirect in drain");
    resetDut(4, 1'b1);
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
    checkOutput("dbl first addr", imemAddr, 32'h0);
    applyStimulus(1'b1, 32'h400, 1'b1, 1'b0);
    checkOutput("dbl drain addr", imemAddr, 32'h0);
    repeat (3) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("dbl drain addr", imemAddr, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("dbl resume addr", imemAddr, 32'h400);
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an outstanding request.
    $display("[TB] reset mid-request");
    resetDut(0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    latMin = 5;
    latMax = 5;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midreq count", 32'(count), 32'd2);
    checkOutput("midreq addr", imemAddr, 32'h8);
    #1;
    rstN = 1'b0;
    restartStream(RESET_PC);
    #1;
    checkResetValues("async reset");
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    latMin = 0;
    latMax = 0;
    memLatency = 0;
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("restart req", 32'(imemReq), 32'h1);
    checkOutput("restart addr", imemAddr, RESET_PC);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic: variable latency, stalls, redirects (incl. wrap).
    $display("[TB] random traffic");
    resetDut(0, 1'b1);
    latMax = 3;
    startPops = pops;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        resetDut(2, 1'b1);
        latMin = 0;
        latMax = 3;
      end
      rr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 7) == 0)
        rp = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else
        rp = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(rr, rp, ($urandom_range(0, 3) != 0), 1'b0);
    end
    repeat (30) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("random progress", 32'((pops - startPops) > 300), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
